// File: rtl/vote_pkg.sv
// Shared types and constants for the voting session controller and its tally.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [2:0] RES_PASS = 3'b100;
    localparam logic [2:0] RES_TIE  = 3'b010;
    localparam logic [2:0] RES_FAIL = 3'b001;

    localparam int DEF_N_VOTERS = 4;
    localparam int DEF_TIMEOUT  = 16;

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Ballot channel bundle: voters offer ballots, the controller grants per-voter acceptance.
interface vote_session_ctrl_if #(
    parameter int N_VOTERS = 4
);
    logic [N_VOTERS-1:0] vote_valid;
    logic [N_VOTERS-1:0] vote_val;
    logic [N_VOTERS-1:0] vote_ready;

    modport master (output vote_valid, output vote_val, input vote_ready);
    modport slave  (input vote_valid, input vote_val, output vote_ready);
endinterface

// File: rtl/vote_tally.sv
// Combinational yes/no comparison producing the one-hot {pass, tie, fail} result.
module vote_tally
    import vote_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] yes,
    input  logic [W-1:0] no,
    output logic [2:0]   result
);

    always_comb begin
        if (yes > no) begin
            result = RES_PASS;
        end else if (yes == no) begin
            result = RES_TIE;
        end else begin
            result = RES_FAIL;
        end
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session controller: opens a session, collects one ballot per voter until
// everyone has voted or the timer expires, then holds the tallied result until acked.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int N_VOTERS = DEF_N_VOTERS,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            ack,
    vote_session_ctrl_if.slave              ballot,
    output logic                            busy,
    output logic                            done,
    output logic [2:0]                      result,
    output logic [$clog2(N_VOTERS+1)-1:0]   yes_cnt,
    output logic [N_VOTERS-1:0]             voted_mask,
    output logic                            timed_out
);

    localparam int CW = $clog2(N_VOTERS+1);

    state_t              state;
    state_t              state_next;
    logic [7:0]          timer;
    logic [CW-1:0]       no_cnt;
    logic [N_VOTERS-1:0] ready;
    logic [N_VOTERS-1:0] accept;
    logic [N_VOTERS-1:0] mask_next;
    logic [CW-1:0]       yes_inc;
    logic [CW-1:0]       no_inc;
    logic                all_in;
    logic                timeout_hit;
    logic [2:0]          tally_res;

    assign ballot.vote_ready = ready;

    // Accepts of this cycle are folded in before deciding whether COLLECT is over.
    always_comb begin
        accept      = ballot.vote_valid & ready;
        mask_next   = voted_mask | accept;
        all_in      = &mask_next;
        timeout_hit = (timer == 8'(TIMEOUT - 1));
        yes_inc     = '0;
        no_inc      = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            if (accept[i]) begin
                if (ballot.vote_val[i]) begin
                    yes_inc = yes_inc + CW'(1);
                end else begin
                    no_inc = no_inc + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (all_in || timeout_hit) state_next = DECIDE;
            DECIDE:  state_next = HOLD;
            HOLD:    if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = '0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            COLLECT: begin
                ready = ~voted_mask;
                busy  = 1'b1;
            end
            DECIDE:  busy = 1'b1;
            HOLD:    done = 1'b1;
            default: ;
        endcase
    end

    vote_tally #(.W(CW)) u_tally (
        .yes    (yes_cnt),
        .no     (no_cnt),
        .result (tally_res)
    );

    // Session results stay untouched in IDLE and HOLD so the consumer can read them late.
    always_ff @(posedge clk) begin
        if (rst) begin
            voted_mask <= '0;
            yes_cnt    <= '0;
            no_cnt     <= '0;
            timer      <= '0;
            timed_out  <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        voted_mask <= '0;
                        yes_cnt    <= '0;
                        no_cnt     <= '0;
                        timer      <= '0;
                        timed_out  <= 1'b0;
                        result     <= '0;
                    end
                end
                COLLECT: begin
                    voted_mask <= mask_next;
                    yes_cnt    <= yes_cnt + yes_inc;
                    no_cnt     <= no_cnt + no_inc;
                    timer      <= timer + 8'd1;
                    if (timeout_hit && !all_in) begin
                        timed_out <= 1'b1;
                    end
                end
                DECIDE:  result <= tally_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl with hand-computed expectations (N_VOTERS=4, TIMEOUT=16).
module tb_vote_session_ctrl;
    import vote_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ack;
    logic       busy;
    logic       done;
    logic [2:0] result;
    logic [2:0] yes_cnt;
    logic [3:0] voted_mask;
    logic       timed_out;

    int total = 0;
    int bad   = 0;

    vote_session_ctrl_if #(.N_VOTERS(4)) bus ();

    vote_session_ctrl #(.N_VOTERS(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ack        (ack),
        .ballot     (bus.slave),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .yes_cnt    (yes_cnt),
        .voted_mask (voted_mask),
        .timed_out  (timed_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the edge that samples them.
    task automatic applyStimulus(input logic s, input logic a, input logic [3:0] vv, input logic [3:0] vl);
        start          = s;
        ack            = a;
        bus.vote_valid = vv;
        bus.vote_val   = vl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        rst = 1'b0;
        checkOutput("rst_busy",   32'(busy), 0);
        checkOutput("rst_done",   32'(done), 0);
        checkOutput("rst_result", 32'(result), 0);
        checkOutput("rst_yes",    32'(yes_cnt), 0);
        checkOutput("rst_mask",   32'(voted_mask), 0);
        checkOutput("rst_to",     32'(timed_out), 0);
        checkOutput("rst_ready",  32'(bus.vote_ready), 0);

        // Scenario 1: everyone votes in the first COLLECT cycle, 3 yes / 1 no.
        applyStimulus(1, 0, 4'b0000, 4'b0000);
        checkOutput("s1_busy",  32'(busy), 1);
        checkOutput("s1_ready", 32'(bus.vote_ready), 'b1111);
        applyStimulus(0, 0, 4'b1111, 4'b0111);
        checkOutput("s1_dec_busy",  32'(busy), 1);
        checkOutput("s1_dec_done",  32'(done), 0);
        checkOutput("s1_dec_ready", 32'(bus.vote_ready), 0);
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s1_done",   32'(done), 1);
        checkOutput("s1_busy2",  32'(busy), 0);
        checkOutput("s1_result", 32'(result), 'b100);
        checkOutput("s1_yes",    32'(yes_cnt), 3);
        checkOutput("s1_mask",   32'(voted_mask), 'b1111);
        checkOutput("s1_to",     32'(timed_out), 0);
        applyStimulus(0, 0, 4'b1111, 4'b0000);
        checkOutput("s1_hold_done", 32'(done), 1);
        checkOutput("s1_hold_yes",  32'(yes_cnt), 3);
        applyStimulus(0, 1, 4'b0000, 4'b0000);
        checkOutput("s1_idle_done",   32'(done), 0);
        checkOutput("s1_idle_result", 32'(result), 'b100);
        checkOutput("s1_idle_yes",    32'(yes_cnt), 3);

        // Scenario 2: two voters only, session closes by timeout after 16 cycles.
        applyStimulus(1, 0, 4'b0000, 4'b0000);
        applyStimulus(0, 0, 4'b0011, 4'b0001);
        checkOutput("s2_mask",  32'(voted_mask), 'b0011);
        checkOutput("s2_yes",   32'(yes_cnt), 1);
        checkOutput("s2_ready", 32'(bus.vote_ready), 'b1100);
        repeat (14) applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s2_c16_busy",  32'(busy), 1);
        checkOutput("s2_c16_ready", 32'(bus.vote_ready), 'b1100);
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s2_dec_busy", 32'(busy), 1);
        checkOutput("s2_dec_done", 32'(done), 0);
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s2_done",   32'(done), 1);
        checkOutput("s2_result", 32'(result), 'b010);
        checkOutput("s2_yes2",   32'(yes_cnt), 1);
        checkOutput("s2_mask2",  32'(voted_mask), 'b0011);
        checkOutput("s2_to",     32'(timed_out), 1);
        applyStimulus(0, 1, 4'b0000, 4'b0000);

        // Scenario 3: channel 2 re-offers after voting; last ballot lands on the timeout cycle.
        applyStimulus(1, 0, 4'b0000, 4'b0000);
        applyStimulus(0, 0, 4'b0100, 4'b0100);
        checkOutput("s3_yes",   32'(yes_cnt), 1);
        checkOutput("s3_ready", 32'(bus.vote_ready), 'b1011);
        applyStimulus(0, 0, 4'b0100, 4'b0000);
        checkOutput("s3_dup1_yes", 32'(yes_cnt), 1);
        applyStimulus(0, 0, 4'b0100, 4'b0000);
        checkOutput("s3_dup2_yes",  32'(yes_cnt), 1);
        checkOutput("s3_dup2_mask", 32'(voted_mask), 'b0100);
        repeat (12) applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s3_c16_busy",  32'(busy), 1);
        checkOutput("s3_c16_ready", 32'(bus.vote_ready), 'b1011);
        applyStimulus(0, 0, 4'b1000, 4'b0000);
        checkOutput("s3_dec_mask", 32'(voted_mask), 'b1100);
        checkOutput("s3_dec_busy", 32'(busy), 1);
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s3_done",   32'(done), 1);
        checkOutput("s3_result", 32'(result), 'b010);
        checkOutput("s3_yes2",   32'(yes_cnt), 1);
        checkOutput("s3_to",     32'(timed_out), 1);

        // Scenario 6: start and ack both held for three cycles from HOLD.
        applyStimulus(1, 1, 4'b0000, 4'b0000);
        checkOutput("s6_idle_done",   32'(done), 0);
        checkOutput("s6_idle_busy",   32'(busy), 0);
        checkOutput("s6_idle_result", 32'(result), 'b010);
        applyStimulus(1, 1, 4'b0000, 4'b0000);
        checkOutput("s6_new_busy",   32'(busy), 1);
        checkOutput("s6_new_mask",   32'(voted_mask), 0);
        checkOutput("s6_new_yes",    32'(yes_cnt), 0);
        checkOutput("s6_new_to",     32'(timed_out), 0);
        checkOutput("s6_new_result", 32'(result), 0);
        applyStimulus(1, 1, 4'b0000, 4'b0000);
        checkOutput("s6_c2_busy", 32'(busy), 1);
        checkOutput("s6_c2_done", 32'(done), 0);

        // Scenario 4: the same session receives no ballots and times out.
        repeat (14) applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s4_c16_busy", 32'(busy), 1);
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s4_done",   32'(done), 1);
        checkOutput("s4_result", 32'(result), 'b010);
        checkOutput("s4_yes",    32'(yes_cnt), 0);
        checkOutput("s4_mask",   32'(voted_mask), 0);
        checkOutput("s4_to",     32'(timed_out), 1);
        applyStimulus(0, 1, 4'b0000, 4'b0000);

        // Scenario 5: reset mid-session, then a clean fail session.
        applyStimulus(1, 0, 4'b0000, 4'b0000);
        applyStimulus(0, 0, 4'b0101, 4'b0001);
        checkOutput("s5_mask", 32'(voted_mask), 'b0101);
        checkOutput("s5_yes",  32'(yes_cnt), 1);
        rst = 1'b1;
        applyStimulus(1, 1, 4'b1111, 4'b1111);
        rst = 1'b0;
        checkOutput("s5_rst_busy",  32'(busy), 0);
        checkOutput("s5_rst_done",  32'(done), 0);
        checkOutput("s5_rst_mask",  32'(voted_mask), 0);
        checkOutput("s5_rst_yes",   32'(yes_cnt), 0);
        checkOutput("s5_rst_ready", 32'(bus.vote_ready), 0);
        checkOutput("s5_rst_to",    32'(timed_out), 0);
        applyStimulus(0, 0, 4'b1111, 4'b1111);
        checkOutput("s5_idle_mask", 32'(voted_mask), 0);
        checkOutput("s5_idle_busy", 32'(busy), 0);
        applyStimulus(1, 0, 4'b0000, 4'b0000);
        applyStimulus(0, 0, 4'b1111, 4'b0001);
        applyStimulus(0, 0, 4'b0000, 4'b0000);
        checkOutput("s5_done",   32'(done), 1);
        checkOutput("s5_result", 32'(result), 'b001);
        checkOutput("s5_yes2",   32'(yes_cnt), 1);
        checkOutput("s5_mask2",  32'(voted_mask), 'b1111);
        checkOutput("s5_to",     32'(timed_out), 0);
        applyStimulus(0, 1, 4'b0000, 4'b0000);
        checkOutput("s5_end_done", 32'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
